// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and EX-side resolution bundle shared by the predictor and its driver.
interface branch_predictor_if;
  logic [31:0] if_pc_i;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        pred_hit_o;
  logic        ex_valid_i;
  logic [31:0] ex_pc_i;
  logic        ex_is_br_i;
  logic        ex_is_uncbr_i;
  logic        ex_taken_i;
  logic [31:0] ex_target_i;
  logic        ex_pred_taken_i;
  logic [31:0] ex_pred_target_i;
  logic        mispredict_o;
  logic [31:0] redirect_pc_o;
  logic [31:0] br_count_o;
  logic [31:0] mispred_count_o;

  modport master (
    output if_pc_i, ex_valid_i, ex_pc_i, ex_is_br_i, ex_is_uncbr_i, ex_taken_i,
           ex_target_i, ex_pred_taken_i, ex_pred_target_i,
    input  pred_taken_o, pred_target_o, pred_hit_o, mispredict_o, redirect_pc_o,
           br_count_o, mispred_count_o
  );

  modport slave (
    input  if_pc_i, ex_valid_i, ex_pc_i, ex_is_br_i, ex_is_uncbr_i, ex_taken_i,
           ex_target_i, ex_pred_taken_i, ex_pred_target_i,
    output pred_taken_o, pred_target_o, pred_hit_o, mispredict_o, redirect_pc_o,
           br_count_o, mispred_count_o
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: zero-latency fetch lookup,
// EX-stage training, mispredict detection and branch/mispredict counters.
module branch_predictor #(
  parameter int ENTRIES = 16,
  localparam int IDX_W = $clog2(ENTRIES),
  localparam int TAG_W = 30 - IDX_W
) (
  input logic clk_i,
  input logic rst_i,
  branch_predictor_if.slave bp
);

  logic             valid_r  [ENTRIES];
  logic [TAG_W-1:0] tag_r    [ENTRIES];
  logic [31:0]      target_r [ENTRIES];
  logic [1:0]       ctr_r    [ENTRIES];
  logic [31:0]      br_count_r;
  logic [31:0]      mispred_count_r;

  logic [IDX_W-1:0] lk_idx_s;
  logic [TAG_W-1:0] lk_tag_s;
  logic             lk_hit_s;
  logic             lk_taken_s;
  logic [IDX_W-1:0] ex_idx_s;
  logic [TAG_W-1:0] ex_tag_s;
  logic             ex_hit_s;
  logic             is_cf_s;
  logic             act_s;
  logic             mispredict_s;
  logic             unused_pc_bits_s;

  assign unused_pc_bits_s = ^{bp.if_pc_i[1:0], bp.ex_pc_i[1:0]};

  // Lookup reads the registered table directly, so a same-cycle update is not bypassed.
  assign lk_idx_s   = bp.if_pc_i[IDX_W+1:2];
  assign lk_tag_s   = bp.if_pc_i[31:IDX_W+2];
  assign lk_hit_s   = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s);
  assign lk_taken_s = lk_hit_s && ctr_r[lk_idx_s][1];

  assign bp.pred_hit_o    = lk_hit_s;
  assign bp.pred_taken_o  = lk_taken_s;
  assign bp.pred_target_o = lk_taken_s ? target_r[lk_idx_s] : (bp.if_pc_i + 32'd4);

  assign ex_idx_s     = bp.ex_pc_i[IDX_W+1:2];
  assign ex_tag_s     = bp.ex_pc_i[31:IDX_W+2];
  assign ex_hit_s     = valid_r[ex_idx_s] && (tag_r[ex_idx_s] == ex_tag_s);
  assign is_cf_s      = bp.ex_is_br_i | bp.ex_is_uncbr_i;
  assign act_s        = is_cf_s & bp.ex_taken_i;
  assign mispredict_s = bp.ex_valid_i &&
                        ((act_s != bp.ex_pred_taken_i) ||
                         (act_s && (bp.ex_target_i != bp.ex_pred_target_i)));

  assign bp.mispredict_o    = mispredict_s;
  assign bp.redirect_pc_o   = act_s ? bp.ex_target_i : (bp.ex_pc_i + 32'd4);
  assign bp.br_count_o      = br_count_r;
  assign bp.mispred_count_o = mispred_count_r;

  // Table training and performance counting; reset wins over any in-flight update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= '0;
        target_r[i] <= 32'd0;
        ctr_r[i]    <= 2'b01;
      end
      br_count_r      <= 32'd0;
      mispred_count_r <= 32'd0;
    end else if (bp.ex_valid_i) begin
      if (is_cf_s) begin
        br_count_r <= br_count_r + 32'd1;
      end
      if (mispredict_s) begin
        mispred_count_r <= mispred_count_r + 32'd1;
      end
      if (ex_hit_s) begin
        if (bp.ex_is_uncbr_i) begin
          ctr_r[ex_idx_s]    <= 2'b11;
          target_r[ex_idx_s] <= bp.ex_target_i;
        end else if (bp.ex_is_br_i) begin
          if (bp.ex_taken_i) begin
            target_r[ex_idx_s] <= bp.ex_target_i;
            if (ctr_r[ex_idx_s] != 2'b11) begin
              ctr_r[ex_idx_s] <= ctr_r[ex_idx_s] + 2'b01;
            end
          end else if (ctr_r[ex_idx_s] != 2'b00) begin
            ctr_r[ex_idx_s] <= ctr_r[ex_idx_s] - 2'b01;
          end
        end else begin
          // A non-branch sitting at a cached PC means the entry is stale.
          valid_r[ex_idx_s] <= 1'b0;
        end
      end else if (act_s) begin
        valid_r[ex_idx_s]  <= 1'b1;
        tag_r[ex_idx_s]    <= ex_tag_s;
        target_r[ex_idx_s] <= bp.ex_target_i;
        ctr_r[ex_idx_s]    <= bp.ex_is_uncbr_i ? 2'b11 : 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: stimulus pushes expectations from a PC-keyed reference model,
// a negedge monitor pops and compares against the predictor outputs.
module tb_branch_predictor;
  localparam int ENTRIES = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_predictor_if bp ();
  branch_predictor #(.ENTRIES(ENTRIES)) dut (.clk_i(clk), .rst_i(rst), .bp(bp));

  typedef struct {
    logic        hit;
    logic        taken;
    logic [31:0] target;
    logic        ev;
    logic        mis;
    logic [31:0] redirect;
    logic [31:0] brc;
    logic [31:0] misc;
  } exp_t;

  exp_t sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: each slot remembers the full PC of the branch that owns it.
  bit          m_valid [ENTRIES];
  logic [31:0] m_pc    [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  logic [31:0] m_brc;
  logic [31:0] m_misc;

  function automatic int slot_of(logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    int s = slot_of(pc);
    return m_valid[s] && ((m_pc[s] >> 2) == (pc >> 2));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_pc[i]    = 32'd0;
      m_tgt[i]   = 32'd0;
      m_ctr[i]   = 1;
    end
    m_brc  = 32'd0;
    m_misc = 32'd0;
  endtask

  task automatic model_update(input logic [31:0] epc, input bit br, input bit unc,
                              input bit tk, input logic [31:0] tgt, input bit mis);
    int s = slot_of(epc);
    bit h = m_hit(epc);
    if (br || unc) m_brc = m_brc + 32'd1;
    if (mis) m_misc = m_misc + 32'd1;
    if (h) begin
      if (unc) begin
        m_ctr[s] = 3;
        m_tgt[s] = tgt;
      end else if (br) begin
        if (tk) begin
          m_ctr[s] = (m_ctr[s] == 3) ? 3 : m_ctr[s] + 1;
          m_tgt[s] = tgt;
        end else begin
          m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
        end
      end else begin
        m_valid[s] = 1'b0;
      end
    end else if ((br || unc) && tk) begin
      m_valid[s] = 1'b1;
      m_pc[s]    = epc;
      m_tgt[s]   = tgt;
      m_ctr[s]   = unc ? 3 : 2;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs, queue the expected response, then advance the model.
  task automatic step(input bit r, input logic [31:0] fpc, input bit ev,
                      input logic [31:0] epc, input bit br, input bit unc, input bit tk,
                      input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
    exp_t e;
    bit act;
    int s;
    rst = r;
    bp.if_pc_i          = fpc;
    bp.ex_valid_i       = ev;
    bp.ex_pc_i          = epc;
    bp.ex_is_br_i       = br;
    bp.ex_is_uncbr_i    = unc;
    bp.ex_taken_i       = tk;
    bp.ex_target_i      = tgt;
    bp.ex_pred_taken_i  = ptk;
    bp.ex_pred_target_i = ptgt;
    s = slot_of(fpc);
    e.hit    = m_hit(fpc);
    e.taken  = e.hit && (m_ctr[s] >= 2);
    e.target = e.taken ? m_tgt[s] : fpc + 32'd4;
    act = (br || unc) && tk;
    e.ev       = ev;
    e.mis      = ev && ((act != ptk) || (act && (tgt != ptgt)));
    e.redirect = act ? tgt : epc + 32'd4;
    e.brc      = m_brc;
    e.misc     = m_misc;
    sb_q.push_back(e);
    @(posedge clk);
    if (r) model_reset();
    else if (ev) model_update(epc, br, unc, tk, tgt, e.mis);
    #1;
  endtask

  task automatic look(input logic [31:0] fpc);
    step(1'b0, fpc, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Monitor: the predictor answers every cycle, so one expectation is consumed per negedge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("pred_hit", {31'd0, bp.pred_hit_o}, {31'd0, e.hit});
      chk("pred_taken", {31'd0, bp.pred_taken_o}, {31'd0, e.taken});
      chk("pred_target", bp.pred_target_o, e.target);
      chk("mispredict", {31'd0, bp.mispredict_o}, {31'd0, e.mis});
      if (e.ev) chk("redirect_pc", bp.redirect_pc_o, e.redirect);
      chk("br_count", bp.br_count_o, e.brc);
      chk("mispred_count", bp.mispred_count_o, e.misc);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] fpc, epc, tgt, ptgt;
    int kind;
    bp.if_pc_i = 32'h0; bp.ex_valid_i = 1'b0; bp.ex_pc_i = 32'h0;
    bp.ex_is_br_i = 1'b0; bp.ex_is_uncbr_i = 1'b0; bp.ex_taken_i = 1'b0;
    bp.ex_target_i = 32'h0; bp.ex_pred_taken_i = 1'b0; bp.ex_pred_target_i = 32'h0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    model_reset();
    #1;

    look(32'h100);
    // Cold taken branch allocates; lookup the next cycle hits with weakly-taken.
    step(1'b0, 32'h200, 1'b1, 32'h200, 1'b1, 1'b0, 1'b1, 32'h240, 1'b0, 32'h204);
    look(32'h200);
    // Same-cycle lookup sees the old counter; decrement to zero then saturate up.
    step(1'b0, 32'h200, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 32'h240, 1'b1, 32'h240);
    step(1'b0, 32'h200, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 32'h240, 1'b0, 32'h204);
    step(1'b0, 32'h200, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 32'h240, 1'b0, 32'h204);
    look(32'h200);
    for (int i = 0; i < 4; i++)
      step(1'b0, 32'h200, 1'b1, 32'h200, 1'b1, 1'b0, 1'b1, 32'h240, 1'b0, 32'h204);
    look(32'h200);
    // JAL: learn 0x380, then retarget to 0x400.
    step(1'b0, 32'h300, 1'b1, 32'h300, 1'b0, 1'b1, 1'b1, 32'h380, 1'b0, 32'h304);
    step(1'b0, 32'h300, 1'b1, 32'h300, 1'b0, 1'b1, 1'b1, 32'h400, 1'b1, 32'h380);
    look(32'h300);
    // Alias at +4*ENTRIES evicts the original owner.
    step(1'b0, 32'h500, 1'b1, 32'h500, 1'b1, 1'b0, 1'b1, 32'h600, 1'b0, 32'h504);
    step(1'b0, 32'h540, 1'b1, 32'h540, 1'b1, 1'b0, 1'b1, 32'h700, 1'b0, 32'h544);
    look(32'h500);
    look(32'h540);
    // Non-branch at a cached PC invalidates; not-taken miss allocates nothing.
    step(1'b0, 32'h540, 1'b1, 32'h540, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h544);
    look(32'h540);
    step(1'b0, 32'h580, 1'b1, 32'h580, 1'b1, 1'b0, 1'b0, 32'h900, 1'b0, 32'h584);
    look(32'h580);
    look(32'hFFFF_FFFC);
    // Reset with an update in flight: update dropped, table cleared.
    step(1'b1, 32'h300, 1'b1, 32'h300, 1'b0, 1'b1, 1'b1, 32'h800, 1'b0, 32'h304);
    look(32'h300);
    look(32'h200);

    for (int n = 0; n < 400; n++) begin
      fpc  = 32'h200 + 32'(4 * $urandom_range(0, 2 * ENTRIES - 1));
      epc  = ($urandom_range(0, 1) == 1) ? fpc
                                         : 32'h200 + 32'(4 * $urandom_range(0, 2 * ENTRIES - 1));
      tgt  = 32'h1000 + 32'(4 * $urandom_range(0, 7));
      ptgt = ($urandom_range(0, 1) == 1) ? tgt : 32'h1000 + 32'(4 * $urandom_range(0, 7));
      kind = $urandom_range(0, 2);
      step(($urandom_range(0, 59) == 0), fpc, ($urandom_range(0, 3) != 0), epc,
           (kind == 1), (kind == 2), $urandom_range(0, 1) == 1, tgt,
           $urandom_range(0, 1) == 1, ptgt);
    end

    @(negedge clk);
    #1;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
